stream_demux_1to2: RTL and testbench

Registered 1-to-2 stream demultiplexer. It steers each accepted input word to one of two output streams, chosen by a per-word select bit. Each output has its own 2-entry buffer, so a stall on one output never blocks words bound for the other. It sits between a single producer (for example, a writeback or result bus) and two consumers that each apply valid/ready backpressure.

---
 rtl/stream_demux_1to2_if.sv | 37 +++
 rtl/stream_demux_1to2.sv | 97 +++++++++
 tb/tb_stream_demux_1to2.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1to2_if.sv
// rtl/stream_demux_1to2_if.sv - handshake bundle for the 1-to-2 stream demultiplexer
//
// One input stream (valid/ready/sel/data) and two output streams
// (valid/ready/data plus buffer occupancy count).
// Modports:
//   master - the producer and both consumers (drives in_*, out*_ready)
//   slave  - the demultiplexer itself (drives in_ready, out*_valid/data/count)
interface stream_demux_1to2_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic [1:0]       out0_count;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [1:0]       out1_count;

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_count,
               out1_valid, out1_data, out1_count
    );

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_count,
               out1_valid, out1_data, out1_count
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// rtl/stream_demux_1to2.sv - registered 1-to-2 stream demultiplexer with 2-entry output buffers
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, released synchronously upstream
//   bus   - stream_demux_1to2_if.slave: input stream steered by in_sel to
//           out0 (sel 0) or out1 (sel 1); each output has its own
//           head/tail buffer so a stall on one never blocks the other.
module stream_demux_1to2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_demux_1to2_if.slave   bus
);

    // Encoding equals the occupancy, so the state drives outN_count directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t      state [2];
    logic [WIDTH-1:0] head  [2];
    logic [WIDTH-1:0] tail  [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;
    logic       accept;

    assign out_ready[0] = bus.out0_ready;
    assign out_ready[1] = bus.out1_ready;

    // Readiness looks only at the selected buffer's occupancy; a FULL buffer
    // refuses even when it is popping this cycle, keeping in_ready free of any
    // path from the consumers' ready inputs.
    assign bus.in_ready = (bus.in_sel ? state[1] : state[0]) != FULL;
    assign accept       = bus.in_valid && bus.in_ready;

    assign push[0] = accept && !bus.in_sel;
    assign push[1] = accept &&  bus.in_sel;
    assign pop[0]  = (state[0] != EMPTY) && out_ready[0];
    assign pop[1]  = (state[1] != EMPTY) && out_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= EMPTY;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    EMPTY: begin
                        if (push[i]) begin
                            head[i]  <= bus.in_data;
                            state[i] <= ONE;
                        end
                    end
                    ONE: begin
                        if (push[i] && pop[i]) begin
                            // Head leaves and the new word replaces it.
                            head[i] <= bus.in_data;
                        end else if (push[i]) begin
                            tail[i]  <= bus.in_data;
                            state[i] <= FULL;
                        end else if (pop[i]) begin
                            state[i] <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready blocks pushes here, so only a pop can occur.
                        if (pop[i]) begin
                            head[i]  <= tail[i];
                            state[i] <= ONE;
                        end
                    end
                    default: begin
                        state[i] <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.out0_valid = (state[0] != EMPTY);
    assign bus.out0_data  = head[0];
    assign bus.out0_count = state[0];

    assign bus.out1_valid = (state[1] != EMPTY);
    assign bus.out1_data  = head[1];
    assign bus.out1_count = state[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb/tb_stream_demux_1to2.sv - directed and soak checks for stream_demux_1to2
module tb_stream_demux_1to2;

    logic clk;
    logic rst_n;

    stream_demux_1to2_if #(.WIDTH(32)) bus ();

    stream_demux_1to2 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          sent;
    int          cyc;
    logic        acc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        // Reset state
        step();
        check_eq("rst_out0_valid", bus.out0_valid, 0);
        check_eq("rst_out1_valid", bus.out1_valid, 0);
        check_eq("rst_out0_count", bus.out0_count, 0);
        check_eq("rst_out1_count", bus.out1_count, 0);
        check_eq("rst_out0_data", bus.out0_data, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // Reset mid-stream: fill out0 with 0xA, 0xB then reset between edges
        drive(1'b1, 1'b0, 32'hA);
        step();
        drive(1'b1, 1'b0, 32'hB);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check_eq("mid_fill_count", bus.out0_count, 2);
        check_eq("mid_fill_head", bus.out0_data, 32'hA);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus.out0_valid, 0);
        check_eq("mid_rst_count", bus.out0_count, 0);
        check_eq("mid_rst_in_ready", bus.in_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_rst_valid", bus.out0_valid, 0);
        check_eq("post_rst_data", bus.out0_data, 0);

        // Alternating select, both readys high
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h11);
        #1 check_eq("alt_rdy0", bus.in_ready, 1);
        step();
        check_eq("alt_o0_v_11", bus.out0_valid, 1);
        check_eq("alt_o0_d_11", bus.out0_data, 32'h11);
        check_eq("alt_o1_v_0", bus.out1_valid, 0);
        drive(1'b1, 1'b1, 32'h22);
        #1 check_eq("alt_rdy1", bus.in_ready, 1);
        step();
        check_eq("alt_o1_v_22", bus.out1_valid, 1);
        check_eq("alt_o1_d_22", bus.out1_data, 32'h22);
        check_eq("alt_o0_v_gone", bus.out0_valid, 0);
        drive(1'b1, 1'b0, 32'h33);
        #1 check_eq("alt_rdy2", bus.in_ready, 1);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check_eq("alt_o0_v_33", bus.out0_valid, 1);
        check_eq("alt_o0_d_33", bus.out0_data, 32'h33);
        check_eq("alt_o1_v_gone", bus.out1_valid, 0);
        step();
        check_eq("alt_o0_drained", bus.out0_count, 0);

        // Backpressure fill on out0
        bus.out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h1);
        step();
        drive(1'b1, 1'b0, 32'h2);
        step();
        drive(1'b1, 1'b0, 32'h3);
        #1;
        check_eq("bp_count_full", bus.out0_count, 2);
        check_eq("bp_in_ready_low", bus.in_ready, 0);
        check_eq("bp_head_1", bus.out0_data, 32'h1);
        step();
        check_eq("bp_held_count", bus.out0_count, 2);
        check_eq("bp_held_head", bus.out0_data, 32'h1);
        bus.out0_ready = 1'b1;
        #1 check_eq("bp_full_refuses_while_pop", bus.in_ready, 0);
        step();
        check_eq("bp_pop1_count", bus.out0_count, 1);
        check_eq("bp_pop1_head_2", bus.out0_data, 32'h2);
        check_eq("bp_recover_ready", bus.in_ready, 1);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check_eq("bp_head_3", bus.out0_data, 32'h3);
        check_eq("bp_count_3", bus.out0_count, 1);
        step();
        check_eq("bp_drained", bus.out0_count, 0);

        // Independence: out0 FULL and stalled, push to out1
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h1);
        step();
        drive(1'b1, 1'b0, 32'h2);
        step();
        drive(1'b1, 1'b1, 32'h55);
        #1 check_eq("ind_in_ready", bus.in_ready, 1);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check_eq("ind_o1_valid", bus.out1_valid, 1);
        check_eq("ind_o1_data", bus.out1_data, 32'h55);
        check_eq("ind_o0_data", bus.out0_data, 32'h1);
        check_eq("ind_o0_count", bus.out0_count, 2);
        bus.out0_ready = 1'b1;
        step();
        step();
        check_eq("ind_o0_drained", bus.out0_count, 0);
        check_eq("ind_o1_drained", bus.out1_count, 0);

        // Simultaneous push and pop while ONE
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h7);
        step();
        check_eq("pp_o1_data_7", bus.out1_data, 32'h7);
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h8);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check_eq("pp_o1_data_8", bus.out1_data, 32'h8);
        check_eq("pp_o1_count", bus.out1_count, 1);
        step();
        check_eq("pp_o1_drained", bus.out1_count, 0);

        // Stall stability on out1
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h9);
        step();
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_o1_valid", bus.out1_valid, 1);
            check_eq("stall_o1_data", bus.out1_data, 32'h9);
            step();
        end
        bus.out1_ready = 1'b1;
        step();
        check_eq("stall_drained", bus.out1_count, 0);

        // Random soak with per-output scoreboards
        sent = 0;
        cyc  = 0;
        acc  = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        while ((sent < 10000 || q0.size() != 0 || q1.size() != 0) && cyc < 60000) begin
            if (!bus.in_valid || acc) begin
                if (sent < 10000 && $urandom_range(3) != 0)
                    drive(1'b1, 1'($urandom_range(1)), $urandom);
                else
                    drive(1'b0, 1'b0, 32'h0);
            end
            bus.out0_ready = ($urandom_range(9) < 7);
            bus.out1_ready = ($urandom_range(9) < 7);
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out0_valid && bus.out0_ready) begin
                if (q0.size() == 0) check_eq("soak_o0_extra", 1, 0);
                else check_eq("soak_o0", bus.out0_data, q0.pop_front());
            end
            if (bus.out1_valid && bus.out1_ready) begin
                if (q1.size() == 0) check_eq("soak_o1_extra", 1, 0);
                else check_eq("soak_o1", bus.out1_data, q1.pop_front());
            end
            if (acc) begin
                if (bus.in_sel) q1.push_back(bus.in_data);
                else            q0.push_back(bus.in_data);
                sent++;
            end
            step();
            cyc++;
        end
        check_eq("soak_sent", sent, 10000);
        check_eq("soak_q0_left", q0.size(), 0);
        check_eq("soak_q1_left", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
